// File: rtl/phy_rx_nibble_deframer_pkg.sv
// Shared constants for the receive nibble deframer: FSM encoding, control-word
// layout, preamble/SFD nibbles and CRC-32 constants.
package phy_rx_nibble_deframer_pkg;

  localparam int unsigned NIB_W   = 4;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CTRL_W  = 24;
  localparam int unsigned CRC_W   = 32;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_PREAMBLE = 3'd1;
  localparam logic [STATE_W-1:0] ST_LO       = 3'd2;
  localparam logic [STATE_W-1:0] ST_HI       = 3'd3;
  localparam logic [STATE_W-1:0] ST_EOF      = 3'd4;
  localparam logic [STATE_W-1:0] ST_DROP     = 3'd5;

  localparam int unsigned LEN_LSB   = 0;
  localparam int unsigned LEN_MSB   = 11;
  localparam int unsigned ODD_BIT   = 12;
  localparam int unsigned LONG_BIT  = 13;
  localparam int unsigned SHORT_BIT = 14;
  localparam int unsigned CRC_BIT   = 15;

  localparam logic [NIB_W-1:0] PRE_NIB = 4'h5;
  localparam logic [NIB_W-1:0] SFD_NIB = 4'hD;

  // Polynomial is in reflected form; residue is in MSB-first form.
  localparam logic [CRC_W-1:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [CRC_W-1:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [CRC_W-1:0] CRC_RESIDUE = 32'hC704_DD7B;

  function automatic logic [CRC_W-1:0] bitrev32(input logic [CRC_W-1:0] x);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

endpackage

// File: rtl/phy_rx_nibble_deframer_crc32_nibble.sv
// Combinational reflected CRC-32 update by one 4-bit nibble.
module crc32_nibble
  import phy_rx_nibble_deframer_pkg::*;
(
  input  logic [CRC_W-1:0] crc_in,
  input  logic [NIB_W-1:0] nibble,
  output logic [CRC_W-1:0] crc_next_c
);

  always_comb begin
    logic [CRC_W-1:0] c;
    c = crc_in ^ {28'd0, nibble};
    for (int i = 0; i < 4; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_next_c = c;
  end

endmodule

// File: rtl/phy_rx_nibble_deframer.sv
// Receive PHY deframer: strips preamble/SFD, reassembles bytes from nibbles and
// reports an end-of-frame control word. Optional FCS check: RX_CRC_CHECK_EN.
module phy_rx_nibble_deframer
  import phy_rx_nibble_deframer_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned CNT_W   = 12
) (
  input  logic              clk_phy,
  input  logic              reset,
  input  logic [NIB_W-1:0]  phy_data_in,
  input  logic              phy_rx_dv,
  output logic [BYTE_W-1:0] f_data_out,
  output logic              f_rec_data_valid,
  output logic [CTRL_W-1:0] f_ctrl_out,
  output logic              f_rec_frame_valid
);

  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic [STATE_W-1:0] state_q, state_d;
  logic [NIB_W-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               odd_q, odd_d;
  logic               long_q, long_d;
  logic [BYTE_W-1:0]  data_d;
  logic               dvalid_d;
  logic [CTRL_W-1:0]  ctrl_d;
  logic               fvalid_d;
  logic               crc_bad;

`ifdef RX_CRC_CHECK_EN
  logic [CRC_W-1:0] crc_q, crc_d, crc_next;

  crc32_nibble u_crc (
    .crc_in    (crc_q),
    .nibble    (phy_data_in),
    .crc_next_c(crc_next)
  );

  assign crc_bad = (bitrev32(crc_q) != CRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    odd_d    = odd_q;
    long_d   = long_q;
    data_d   = f_data_out;
    dvalid_d = 1'b0;
    ctrl_d   = f_ctrl_out;
    fvalid_d = 1'b0;
`ifdef RX_CRC_CHECK_EN
    crc_d    = crc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (phy_rx_dv) state_d = (phy_data_in == PRE_NIB) ? ST_PREAMBLE : ST_DROP;
      end
      ST_PREAMBLE: begin
`ifdef RX_CRC_CHECK_EN
        crc_d = CRC_INIT;
`endif
        if (!phy_rx_dv)                  state_d = ST_IDLE;
        else if (phy_data_in == SFD_NIB) state_d = ST_LO;
        else if (phy_data_in != PRE_NIB) state_d = ST_DROP;
      end
      ST_LO: begin
        if (!phy_rx_dv) begin
          state_d = ST_EOF;
        end else begin
          lo_d    = phy_data_in;
          state_d = ST_HI;
`ifdef RX_CRC_CHECK_EN
          crc_d   = crc_next;
`endif
        end
      end
      ST_HI: begin
        if (!phy_rx_dv) begin
          odd_d   = 1'b1;
          state_d = ST_EOF;
        end else begin
          state_d = ST_LO;
`ifdef RX_CRC_CHECK_EN
          crc_d   = crc_next;
`endif
          // Bytes past MAX_LEN are counted but not delivered.
          if (cnt_q < MAX_C) begin
            data_d   = {phy_data_in, lo_q};
            dvalid_d = 1'b1;
          end else begin
            long_d = 1'b1;
          end
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EOF: begin
        ctrl_d                   = '0;
        ctrl_d[LEN_MSB:LEN_LSB]  = 12'(cnt_q);
        ctrl_d[ODD_BIT]          = odd_q;
        ctrl_d[LONG_BIT]         = long_q;
        ctrl_d[SHORT_BIT]        = (cnt_q < MIN_C);
        ctrl_d[CRC_BIT]          = crc_bad;
        fvalid_d                 = 1'b1;
        cnt_d                    = '0;
        odd_d                    = 1'b0;
        long_d                   = 1'b0;
        state_d                  = ST_IDLE;
      end
      ST_DROP: begin
        if (!phy_rx_dv) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_phy or posedge reset) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      lo_q              <= '0;
      cnt_q             <= '0;
      odd_q             <= 1'b0;
      long_q            <= 1'b0;
      f_data_out        <= '0;
      f_rec_data_valid  <= 1'b0;
      f_ctrl_out        <= '0;
      f_rec_frame_valid <= 1'b0;
`ifdef RX_CRC_CHECK_EN
      crc_q             <= CRC_INIT;
`endif
    end else begin
      state_q           <= state_d;
      lo_q              <= lo_d;
      cnt_q             <= cnt_d;
      odd_q             <= odd_d;
      long_q            <= long_d;
      f_data_out        <= data_d;
      f_rec_data_valid  <= dvalid_d;
      f_ctrl_out        <= ctrl_d;
      f_rec_frame_valid <= fvalid_d;
`ifdef RX_CRC_CHECK_EN
      crc_q             <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_phy_rx_nibble_deframer.sv
// Self-checking bench for phy_rx_nibble_deframer: directed and random frames
// scored against a byte-level frame model.
module tb_phy_rx_nibble_deframer;

  localparam int unsigned MAX_LEN = 1518;
  localparam int unsigned MIN_LEN = 64;
`ifdef RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk_phy = 1'b0;
  logic        reset;
  logic [3:0]  phy_data_in;
  logic        phy_rx_dv;
  logic [7:0]  f_data_out;
  logic        f_rec_data_valid;
  logic [23:0] f_ctrl_out;
  logic        f_rec_frame_valid;

  phy_rx_nibble_deframer #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .CNT_W(12)) dut (
    .clk_phy          (clk_phy),
    .reset            (reset),
    .phy_data_in      (phy_data_in),
    .phy_rx_dv        (phy_rx_dv),
    .f_data_out       (f_data_out),
    .f_rec_data_valid (f_rec_data_valid),
    .f_ctrl_out       (f_ctrl_out),
    .f_rec_frame_valid(f_rec_frame_valid)
  );

  always #5 clk_phy = ~clk_phy;

  int checks = 0;
  int passes = 0;
  int overlap = 0;
  logic [7:0]  rx_q[$];
  logic [23:0] fr_q[$];
  logic [7:0]  exp_rx[$];
  logic [23:0] exp_fr[$];
  logic [7:0]  fb[$];

  // Capture strobes away from the active edge.
  always @(negedge clk_phy) begin
    if (f_rec_data_valid) rx_q.push_back(f_data_out);
    if (f_rec_frame_valid) fr_q.push_back(f_ctrl_out);
    if (f_rec_data_valid && f_rec_frame_valid) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] crc32(input logic [7:0] b[$], input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'd0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit fcs_ok(input logic [7:0] b[$]);
    int n;
    n = b.size();
    if (n < 4) return 1'b0;
    return crc32(b, n - 4) == {b[n-1], b[n-2], b[n-3], b[n-4]};
  endfunction

  function automatic logic [23:0] model_ctrl(input logic [7:0] b[$], input bit odd);
    int n;
    logic [11:0] len;
    bit crc_bad;
    n = b.size();
    len = (n > 4095) ? 12'hFFF : 12'(n);
    crc_bad = CRC_EN && (odd || !fcs_ok(b));
    return {8'h00, crc_bad, (n < int'(MIN_LEN)), (n > int'(MAX_LEN)), odd, len};
  endfunction

  task automatic nib(input logic dv, input logic [3:0] d);
    @(negedge clk_phy);
    phy_rx_dv   = dv;
    phy_data_in = d;
  endtask

  task automatic preamble();
    repeat (15) nib(1'b1, 4'h5);
    nib(1'b1, 4'hD);
  endtask

  // Drive one frame and record what the model says should come out.
  task automatic run(input logic [7:0] b[$], input bit odd, input int gap);
    for (int i = 0; i < b.size(); i++) if (i < int'(MAX_LEN)) exp_rx.push_back(b[i]);
    exp_fr.push_back(model_ctrl(b, odd));
    preamble();
    foreach (b[i]) begin
      nib(1'b1, b[i][3:0]);
      nib(1'b1, b[i][7:4]);
    end
    if (odd) nib(1'b1, 4'($urandom_range(0, 15)));
    repeat (gap) nib(1'b0, 4'h0);
  endtask

  task automatic verify(input string tag);
    int w;
    int nb;
    w = 0;
    while (fr_q.size() < exp_fr.size() && w < 100) begin
      @(negedge clk_phy);
      w++;
    end
    repeat (4) @(negedge clk_phy);
    chk({tag, " byte_count"}, rx_q.size(), exp_rx.size());
    nb = (rx_q.size() < exp_rx.size()) ? rx_q.size() : exp_rx.size();
    for (int i = 0; i < nb; i++) begin
      chk($sformatf("%s byte[%0d]", tag, i), rx_q[i], exp_rx[i]);
      if (rx_q[i] !== exp_rx[i]) break;
    end
    chk({tag, " frame_count"}, fr_q.size(), exp_fr.size());
    for (int i = 0; i < fr_q.size() && i < exp_fr.size(); i++)
      chk($sformatf("%s ctrl[%0d]", tag, i), fr_q[i], exp_fr[i]);
    rx_q.delete(); fr_q.delete(); exp_rx.delete(); exp_fr.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " data"}, f_data_out, 0);
    chk({tag, " dvalid"}, f_rec_data_valid, 0);
    chk({tag, " ctrl"}, f_ctrl_out, 0);
    chk({tag, " fvalid"}, f_rec_frame_valid, 0);
  endtask

  task automatic rand_bytes(input int n, input bit with_fcs);
    logic [31:0] c;
    fb.delete();
    if (with_fcs && n >= 4) begin
      for (int i = 0; i < n - 4; i++) fb.push_back(8'($urandom_range(0, 255)));
      c = crc32(fb, n - 4);
      for (int i = 0; i < 4; i++) fb.push_back(c[8*i +: 8]);
    end else begin
      for (int i = 0; i < n; i++) fb.push_back(8'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    reset = 1'b1; phy_rx_dv = 1'b0; phy_data_in = 4'h0;
    repeat (3) @(negedge clk_phy);
    chk_reset_outputs("reset_state");
    reset = 1'b0;

    fb.delete();
    for (int i = 0; i < 64; i++) fb.push_back(8'(i));
    run(fb, 1'b0, 3); verify("ramp64");

    fb.delete();
    repeat (512) fb.push_back(8'hEF);
    run(fb, 1'b0, 3); verify("ef512");

    rand_bytes(10, 1'b0);
    run(fb, 1'b1, 3); verify("odd10");

    rand_bytes(1600, 1'b0);
    run(fb, 1'b0, 3); verify("long1600");

    rand_bytes(1518, 1'b0); run(fb, 1'b0, 3); verify("max1518");
    rand_bytes(1519, 1'b0); run(fb, 1'b0, 3); verify("max1519");
    rand_bytes(63, 1'b0);   run(fb, 1'b0, 3); verify("min63");

    fb.delete(); run(fb, 1'b0, 3); verify("zero_len");

    // Corrupt preamble: everything until dv drops is discarded.
    repeat (6) nib(1'b1, 4'h5);
    nib(1'b1, 4'h3);
    repeat (8) nib(1'b1, 4'h5);
    nib(1'b1, 4'hD);
    repeat (40) nib(1'b1, 4'($urandom_range(0, 15)));
    repeat (3) nib(1'b0, 4'h0);
    verify("bad_preamble");

    // Non-preamble nibble out of idle.
    repeat (4) nib(1'b1, 4'hA);
    preamble();
    repeat (20) nib(1'b1, 4'h1);
    repeat (3) nib(1'b0, 4'h0);
    verify("idle_drop");

    // Reset in the middle of a frame: prior bytes were delivered, no frame strobe.
    rand_bytes(10, 1'b0);
    for (int i = 0; i < 10; i++) exp_rx.push_back(fb[i]);
    preamble();
    foreach (fb[i]) begin
      nib(1'b1, fb[i][3:0]);
      nib(1'b1, fb[i][7:4]);
    end
    nib(1'b1, 4'h7);
    @(negedge clk_phy);
    reset = 1'b1; phy_rx_dv = 1'b0;
    repeat (2) @(negedge clk_phy);
    chk_reset_outputs("mid_reset");
    reset = 1'b0;
    rand_bytes(64, 1'b0);
    run(fb, 1'b0, 3); verify("after_reset");

    rand_bytes(64, 1'b1);
    run(fb, 1'b0, 3); verify("fcs_good");
    fb[5] ^= 8'h10;
    run(fb, 1'b0, 3); verify("fcs_bad");

    // Back-to-back: one idle clock, next preamble begins during EOF.
    for (int k = 0; k < 3; k++) begin
      rand_bytes($urandom_range(1, 80), k[0]);
      run(fb, (k == 1), 1);
    end
    verify("back2back");

    for (int k = 0; k < 8; k++) begin
      rand_bytes($urandom_range(0, 150), $urandom_range(0, 1) == 1);
      run(fb, $urandom_range(0, 3) == 0, $urandom_range(1, 4));
    end
    verify("random");

    chk("no_overlap", overlap, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
